// File: rtl/updown_mod_counter_if.sv
// Control and status bundle of the up/down modulus counter.
// The master drives enable/mode/load_value; the counter (slave) returns count and flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] oResult;
    logic             wrap;
    logic             at_max;
    logic             at_zero;

    modport master (
        output enable,
        output mode,
        output load_value,
        input  oResult,
        input  wrap,
        input  at_max,
        input  at_zero
    );

    modport slave (
        input  enable,
        input  mode,
        input  load_value,
        output oResult,
        output wrap,
        output at_max,
        output at_zero
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MAX_VAL with clamped parallel load and a 1-cycle wrap strobe.
// Latency: one clock from enable/mode to oResult/wrap; at_max/at_zero decoded combinationally.
// No backpressure: enable=0 holds. Define COUNTER_SAT_EN for saturating (wrap = "saturated").
module updown_mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic                  clock,
    input  logic                  reset,
    updown_mod_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    // Limit compare precedes the +/-1, so MAX_VAL = 2**WIDTH-1 never overflows.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                MODE_UP: begin
                    if (count_q == MAX) begin
                        wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
                        count_d = MAX;
`else
                        count_d = '0;
`endif
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (count_q == '0) begin
                        wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
                        count_d = '0;
`else
                        count_d = MAX;
`endif
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                MODE_LOAD: count_d = (bus.load_value > MAX) ? MAX : bus.load_value;
                MODE_HOLD: count_d = count_q;
                default:   count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.oResult = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.at_max  = (count_q == MAX);
    assign bus.at_zero = (count_q == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench: directed + random steps on a WIDTH=4/MAX_VAL=9 counter against an arithmetic model,
// plus a full 256-step sweep of the default 8-bit counter.
module tb_updown_mod_counter;
    localparam int MAXV = 9;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   m_cnt  = 0;
    int   m_wrap = 0;

    always #5 clock = ~clock;

    updown_mod_counter_if #(.WIDTH(4)) b4 ();
    updown_mod_counter_if #(.WIDTH(8)) b8 ();

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(MAXV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (b4.slave)
    );

    updown_mod_counter dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (b8.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: modular arithmetic over (MAXV+1) values, or clamping when saturating.
    function automatic void model(input bit rst, input bit en, input bit [1:0] md, input int ld);
        if (rst) begin
            m_cnt  = 0;
            m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (!en) return;
        case (md)
            2'd1: begin
                m_wrap = (m_cnt == MAXV) ? 1 : 0;
`ifdef COUNTER_SAT_EN
                m_cnt = (m_cnt + 1 > MAXV) ? MAXV : m_cnt + 1;
`else
                m_cnt = (m_cnt + 1) % (MAXV + 1);
`endif
            end
            2'd2: begin
                m_wrap = (m_cnt == 0) ? 1 : 0;
`ifdef COUNTER_SAT_EN
                m_cnt = (m_cnt - 1 < 0) ? 0 : m_cnt - 1;
`else
                m_cnt = (m_cnt + MAXV) % (MAXV + 1);
`endif
            end
            2'd3: m_cnt = (ld > MAXV) ? MAXV : ld;
            default: ;
        endcase
    endfunction

    task automatic step(input bit rst, input bit en, input bit [1:0] md, input int ld);
        reset         = rst;
        b4.enable     = en;
        b4.mode       = md;
        b4.load_value = 4'(ld);
        @(posedge clock);
        #1;
        model(rst, en, md, ld);
        check("count",   32'(b4.oResult), 32'(m_cnt));
        check("wrap",    32'(b4.wrap),    32'(m_wrap));
        check("at_max",  32'(b4.at_max),  32'(m_cnt == MAXV));
        check("at_zero", 32'(b4.at_zero), 32'(m_cnt == 0));
    endtask

    initial begin
        reset         = 1'b1;
        b4.enable     = 1'b1;
        b4.mode       = 2'b01;
        b4.load_value = '0;
        b8.enable     = 1'b0;
        b8.mode       = 2'b00;
        b8.load_value = '0;

        // Reset dominates an enabled count-up.
        step(1, 1, 2'd1, 0);
        step(1, 1, 2'd1, 0);
        check("reset_count",   32'(b4.oResult), 32'd0);
        check("reset_at_zero", 32'(b4.at_zero), 32'd1);

        // Count up 12 times through the limit.
        for (int i = 0; i < 12; i++) step(0, 1, 2'd1, 0);

        // Count down from 0.
        step(0, 1, 2'd3, 0);
        step(0, 1, 2'd2, 0);
        step(0, 1, 2'd2, 0);

        // Load, clamped load, disabled load.
        step(0, 1, 2'd3, 6);
        check("load6", 32'(b4.oResult), 32'd6);
        step(0, 1, 2'd3, 15);
        check("load_clamp", 32'(b4.oResult), 32'd9);
        step(0, 0, 2'd3, 3);
        check("load_disabled", 32'(b4.oResult), 32'd9);

        // Reset mid-count, then alternating enable.
        step(0, 1, 2'd3, 5);
        step(0, 1, 2'd1, 0);
        step(1, 1, 2'd1, 0);
        check("midreset", 32'(b4.oResult), 32'd0);
        for (int i = 0; i < 8; i++) step(0, (i % 2) == 0, 2'd1, 0);

        // Limit behaviour both directions; direction change with no dead cycle.
        step(0, 1, 2'd3, 8);
        for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 0);
        step(0, 1, 2'd2, 0);
        step(0, 1, 2'd3, 1);
        for (int i = 0; i < 2; i++) step(0, 1, 2'd2, 0);
        step(0, 1, 2'd1, 0);
        step(0, 1, 2'd0, 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));

        // Default 8-bit counter: 256 ups from 0.
        reset     = 1'b1;
        b4.enable = 1'b0;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        b8.enable = 1'b1;
        b8.mode   = 2'b01;
        for (int i = 0; i < 255; i++) @(posedge clock);
        #1;
        check("w8_255",     32'(b8.oResult), 32'd255);
        check("w8_at_max",  32'(b8.at_max),  32'd1);
        check("w8_wrap_lo", 32'(b8.wrap),    32'd0);
        @(posedge clock);
        #1;
`ifdef COUNTER_SAT_EN
        check("w8_256", 32'(b8.oResult), 32'd255);
`else
        check("w8_256", 32'(b8.oResult), 32'd0);
`endif
        check("w8_wrap", 32'(b8.wrap), 32'd1);
        b8.enable = 1'b0;
        @(posedge clock);
        #1;
        check("w8_wrap_drop", 32'(b8.wrap), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
